serial_tc_deserializer: RTL and testbench
=========================================

// Module: serial_tc_deserializer
// PURPOSE
//  Receive end of the serial two's-complement link. Takes the LSB-first bit stream from the
//  bit-serial two's-complement converter and un-negates it bit by bit (Mealy pass/invert rule).
//  Assembles each WIDTH-bit frame into a parallel word, handed off on a valid/ready handshake.
//  Sits between the serial converter output and the parallel datapath.
// PARAMETERS
//  WIDTH   4   bits per frame / output word width (>=2)
// PORTS
//  t_clk   in   1      clock; all state updates on rising edge
//  r       in   1      reset, synchronous, active-high
//  i       in   1      serial data bit, LSB first
//  i_vld   in   1      i carries a valid bit this cycle
//  sof     in   1      with i_vld: this bit is bit 0 of a new frame (resync)
//  q       out  WIDTH  assembled, decoded word
//  q_vld   out  1      q holds an unconsumed word
//  q_rdy   in   1      consumer accepts q when q_vld && q_rdy
//  ovf     out  1      sticky: a completed word overwrote an unconsumed one
// BEHAVIOUR
//  - Reset (r=1 at edge): q=0, q_vld=0, ovf=0, bit counter cnt=0, shift reg=0, FSM=S_PASS.
//    Reset wins over every other input in the same cycle and aborts any partial frame.
//  - FSM per frame, one transition per accepted bit (i_vld=1):
//    S_PASS: decoded bit d=i; if i=1 -> S_INV, else stay.
//    S_INV : d=~i; stay.  Entering a new frame always restarts in S_PASS.
//  - d shifts into bit position cnt of the shift reg (LSB first); cnt increments, wraps at WIDTH.
//  - i_vld=0: no state, counter or shift change (gaps between bits allowed).
//  - sof=1 with i_vld=1: discard partial frame, treat bit as bit 0 (cnt=0, S_PASS) before applying.
//    sof while i_vld=0 is ignored.
//  - Frame completion: bit with cnt=WIDTH-1 accepted at edge k -> at edge k: q<=full decoded
//    word, q_vld<=1, cnt<=0, FSM<=S_PASS. Latency last bit -> q_vld = same edge (registered).
//  - Handshake: q_vld && q_rdy at edge -> q_vld<=0 (q holds value). q_rdy ignored if q_vld=0.
//  - Completion while q_vld=1 and q_rdy=0: q overwritten, q_vld stays 1, ovf<=1.
//    Completion with q_vld=1 and q_rdy=1 same edge: new word loaded, q_vld stays 1, no ovf.
//  - ovf clears only on reset. No backpressure on the serial side.
//  - Arithmetic: modulo 2^WIDTH; all-zero word decodes to 0; -2^(WIDTH-1) (1000..) maps to itself.
// CONFIGURATION
//  - TC_DECODE_EN defined: pass/invert FSM active as above (q = two's-complement of received word).
//  - TC_DECODE_EN undefined: FSM removed, d=i always; block is a plain framed LSB-first
//    deserializer with identical handshake, sof, ovf and timing.
// TESTING (WIDTH=4, TC_DECODE_EN defined unless noted)
//  1 reset, then bits 0,1,1,0 (sof on first, i_vld=1, q_rdy=0) -> q=4'b1010, q_vld=1 after 4th edge.
//  2 bits 0,0,0,0 -> q=0000; bits 0,0,0,1 -> q=1000 (most-negative self-maps); q_rdy=1 clears q_vld.
//  3 i_vld toggled 1/0 between bits of frame 1,0,0,0 -> q=4'b1111, same as gapless stream.
//  4 two frames back-to-back, q_rdy=0 -> ovf=1, q=second word; repeat with q_rdy=1 -> ovf=0.
//  5 2 bits of a frame, then sof with new frame 0,1,1,0 -> q=4'b1010; r=1 mid-frame -> all outputs 0.
//  6 TC_DECODE_EN undefined: bits 0,1,1,0 -> q=4'b0110.

Source files
------------

// File: rtl/serial_tc_deserializer.sv
// Receive end of the serial two's-complement link: LSB-first frame deserializer with valid/ready output.
// Optional macro TC_DECODE_EN enables the pass/invert decode FSM; when undefined, bits are stored as received.
module serial_tc_deserializer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             t_clk,
   input  logic             r,
   input  logic             i,
   input  logic             i_vld,
   input  logic             sof,
   output logic [WIDTH-1:0] q,
   output logic             q_vld,
   input  logic             q_rdy,
   output logic             ovf
);

   localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] shreg;

   logic [CNT_W-1:0] eff_cnt;
   logic [WIDTH-1:0] shift_nxt;
   logic             d;
   logic             last;

`ifdef TC_DECODE_EN
   typedef enum logic {S_PASS, S_INV} state_t;

   state_t state;
   state_t state_nxt;
   logic   eff_inv;

   // Mealy decode: pass bits through until the first 1, then invert the rest of the frame.
   always_comb begin
      eff_inv   = 1'b0;
      state_nxt = state;
      eff_inv   = !sof && (state == S_INV);
      d         = eff_inv ? ~i : i;
      state_nxt = (eff_inv || i) ? S_INV : S_PASS;
   end
`else
   always_comb begin
      d = i;
   end
`endif

   // A sof bit restarts the frame at bit 0, dropping any partial word.
   always_comb begin
      eff_cnt   = sof ? '0 : cnt;
      shift_nxt = sof ? '0 : shreg;
      shift_nxt[eff_cnt] = d;
      last      = (eff_cnt == LAST_BIT);
   end

   always_ff @(posedge t_clk) begin
      if (r) begin
         q     <= '0;
         q_vld <= 1'b0;
         ovf   <= 1'b0;
         cnt   <= '0;
         shreg <= '0;
`ifdef TC_DECODE_EN
         state <= S_PASS;
`endif
      end else begin
         if (q_vld && q_rdy) begin
            q_vld <= 1'b0;
         end
         if (i_vld) begin
            if (last) begin
               // Completion beats a same-edge handshake; q_vld stays set for the new word.
               q     <= shift_nxt;
               q_vld <= 1'b1;
               if (q_vld && !q_rdy) begin
                  ovf <= 1'b1;
               end
               cnt   <= '0;
               shreg <= '0;
`ifdef TC_DECODE_EN
               state <= S_PASS;
`endif
            end else begin
               cnt   <= eff_cnt + CNT_W'(1);
               shreg <= shift_nxt;
`ifdef TC_DECODE_EN
               state <= state_nxt;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_tc_deserializer.sv
// Scoreboard bench for serial_tc_deserializer (WIDTH=4); expectations follow TC_DECODE_EN.
module tb_serial_tc_deserializer;

   localparam int unsigned W = 4;

   logic         t_clk = 1'b0;
   logic         r     = 1'b0;
   logic         i     = 1'b0;
   logic         i_vld = 1'b0;
   logic         sof   = 1'b0;
   logic         q_rdy = 1'b0;
   logic [W-1:0] q;
   logic         q_vld;
   logic         ovf;

   logic [W-1:0] sb[$];
   logic [W-1:0] exp_w;
   int           n_vec = 0;
   int           n_err = 0;

   serial_tc_deserializer #(.WIDTH(W)) dut (
      .t_clk (t_clk),
      .r     (r),
      .i     (i),
      .i_vld (i_vld),
      .sof   (sof),
      .q     (q),
      .q_vld (q_vld),
      .q_rdy (q_rdy),
      .ovf   (ovf)
   );

   always #5 t_clk = ~t_clk;

   function automatic logic [W-1:0] expect_word(input logic [W-1:0] raw);
`ifdef TC_DECODE_EN
      return W'(-raw);
`else
      return raw;
`endif
   endfunction

   task automatic tick();
      @(posedge t_clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic s, input logic rdy);
      i = b; sof = s; i_vld = 1'b1; q_rdy = rdy;
      tick();
      i_vld = 1'b0; sof = 1'b0; q_rdy = 1'b0;
   endtask

   task automatic idle(input logic rdy);
      i_vld = 1'b0; q_rdy = rdy;
      tick();
      q_rdy = 1'b0;
   endtask

   task automatic do_reset();
      r = 1'b1;
      tick();
      r = 1'b0;
   endtask

   // Sends one raw frame LSB first; rdy_last drives q_rdy alongside the final bit.
   task automatic send_frame(input logic [W-1:0] raw, input logic s, input logic gaps,
                             input logic rdy_last);
      logic [W-1:0] v;
      v = raw;
      sb.push_back(expect_word(raw));
      for (int k = 0; k < W; k++) begin
         send_bit(v[k], (k == 0) ? s : 1'b0, (k == W - 1) ? rdy_last : 1'b0);
         if (gaps && k != W - 1) idle(1'b0);
      end
   endtask

   task automatic test_reset();
      i = 1'b1; i_vld = 1'b1; sof = 1'b1; q_rdy = 1'b1;
      r = 1'b1;
      tick();
      tick();
      r = 1'b0; i_vld = 1'b0; sof = 1'b0; q_rdy = 1'b0;
      n_vec++;
      if (q !== '0) begin n_err++; $display("FAIL reset_q: got %b want 0000", q); end
      n_vec++;
      if (q_vld !== 1'b0) begin n_err++; $display("FAIL reset_q_vld: got %b want 0", q_vld); end
      n_vec++;
      if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
   endtask

   task automatic test_basic();
      sb.push_back(expect_word(4'b0110));
      send_bit(1'b0, 1'b1, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      n_vec++;
      if (q_vld !== 1'b0) begin n_err++; $display("FAIL basic_partial_vld: got %b want 0", q_vld); end
      send_bit(1'b0, 1'b0, 1'b0);
      exp_w = sb.pop_front();
      n_vec++;
      if (q_vld !== 1'b1) begin n_err++; $display("FAIL basic_vld: got %b want 1", q_vld); end
      n_vec++;
      if (q !== exp_w) begin n_err++; $display("FAIL basic_q: got %b want %b", q, exp_w); end
      idle(1'b0);
      n_vec++;
      if (q_vld !== 1'b1) begin n_err++; $display("FAIL basic_hold_vld: got %b want 1", q_vld); end
      idle(1'b1);
      n_vec++;
      if (q_vld !== 1'b0 || q !== exp_w) begin
         n_err++; $display("FAIL basic_consume: got vld=%b q=%b want vld=0 q=%b", q_vld, q, exp_w);
      end
   endtask

   task automatic test_zero_and_min();
      logic [W-1:0] raws[2];
      raws[0] = 4'b0000;
      raws[1] = 4'b1000;
      foreach (raws[n]) begin
         send_frame(raws[n], 1'b1, 1'b0, 1'b0);
         exp_w = sb.pop_front();
         n_vec++;
         if (q_vld !== 1'b1 || q !== exp_w) begin
            n_err++; $display("FAIL zero_min_%0d: got vld=%b q=%b want vld=1 q=%b", n, q_vld, q, exp_w);
         end
         idle(1'b1);
         n_vec++;
         if (q_vld !== 1'b0) begin n_err++; $display("FAIL zero_min_consume_%0d: got %b want 0", n, q_vld); end
      end
   endtask

   task automatic test_gaps();
      send_frame(4'b0001, 1'b1, 1'b1, 1'b0);
      exp_w = sb.pop_front();
      n_vec++;
      if (q_vld !== 1'b1 || q !== exp_w) begin
         n_err++; $display("FAIL gaps: got vld=%b q=%b want vld=1 q=%b", q_vld, q, exp_w);
      end
      idle(1'b1);
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_frame(4'b0011, 1'b1, 1'b0, 1'b0);
      send_frame(4'b0101, 1'b0, 1'b0, 1'b0);
      void'(sb.pop_front());
      exp_w = sb.pop_front();
      n_vec++;
      if (ovf !== 1'b1) begin n_err++; $display("FAIL b2b_ovf: got %b want 1", ovf); end
      n_vec++;
      if (q_vld !== 1'b1 || q !== exp_w) begin
         n_err++; $display("FAIL b2b_q: got vld=%b q=%b want vld=1 q=%b", q_vld, q, exp_w);
      end
      idle(1'b1);
      n_vec++;
      if (ovf !== 1'b1) begin n_err++; $display("FAIL b2b_ovf_sticky: got %b want 1", ovf); end

      do_reset();
      send_frame(4'b0011, 1'b1, 1'b0, 1'b0);
      send_frame(4'b0101, 1'b0, 1'b0, 1'b1);
      void'(sb.pop_front());
      exp_w = sb.pop_front();
      n_vec++;
      if (ovf !== 1'b0) begin n_err++; $display("FAIL b2b_rdy_ovf: got %b want 0", ovf); end
      n_vec++;
      if (q_vld !== 1'b1 || q !== exp_w) begin
         n_err++; $display("FAIL b2b_rdy_q: got vld=%b q=%b want vld=1 q=%b", q_vld, q, exp_w);
      end
      idle(1'b1);
   endtask

   task automatic test_resync();
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_frame(4'b0110, 1'b1, 1'b0, 1'b0);
      exp_w = sb.pop_front();
      n_vec++;
      if (q_vld !== 1'b1 || q !== exp_w) begin
         n_err++; $display("FAIL resync: got vld=%b q=%b want vld=1 q=%b", q_vld, q, exp_w);
      end
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      i = 1'b1; i_vld = 1'b1; sof = 1'b1;
      do_reset();
      i_vld = 1'b0; sof = 1'b0;
      n_vec++;
      if (q !== '0 || q_vld !== 1'b0 || ovf !== 1'b0) begin
         n_err++; $display("FAIL midframe_reset: got q=%b vld=%b ovf=%b want 0000/0/0", q, q_vld, ovf);
      end
      // No sof: the reset alone must have restarted the frame at bit 0.
      send_frame(4'b1100, 1'b0, 1'b0, 1'b0);
      exp_w = sb.pop_front();
      n_vec++;
      if (q_vld !== 1'b1 || q !== exp_w) begin
         n_err++; $display("FAIL post_reset_frame: got vld=%b q=%b want vld=1 q=%b", q_vld, q, exp_w);
      end
      idle(1'b1);
   endtask

   task automatic test_random();
      logic [W-1:0] raw;
      for (int n = 0; n < 12; n++) begin
         raw = W'($urandom);
         send_frame(raw, 1'(n % 2), 1'($urandom_range(0, 1)), 1'b0);
         exp_w = sb.pop_front();
         n_vec++;
         if (q_vld !== 1'b1 || q !== exp_w) begin
            n_err++; $display("FAIL random_%0d raw=%b: got vld=%b q=%b want vld=1 q=%b", n, raw, q_vld, q, exp_w);
         end
         idle(1'b1);
      end
      n_vec++;
      if (ovf !== 1'b0 || q_vld !== 1'b0) begin
         n_err++; $display("FAIL random_end: got ovf=%b vld=%b want 0/0", ovf, q_vld);
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_basic();
      test_zero_and_min();
      test_gaps();
      test_back_to_back();
      do_reset();
      test_resync();
      test_random();
      n_vec++;
      if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
